// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronizes and debounces the nickel/dime/quarter buttons and turns
// one physical press into one coin event, held on c until the soda FSM pulses tot_ld.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20,
    parameter int VAL_W           = 8,
    parameter int NICKEL_VAL      = 5,
    parameter int DIME_VAL        = 10,
    parameter int QUARTER_VAL     = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_nickel,
    input  logic             btn_dime,
    input  logic             btn_quarter,
    input  logic             tot_ld,
    output logic             c,
    output logic [VAL_W-1:0] a,
    output logic             reject
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PENDING  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       pat_q;
    logic [2:0]       s;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             c_q;
    logic             reject_q;
    logic [VAL_W-1:0] a_q;
    logic             patOneHot;
    logic [VAL_W-1:0] patValue;

    assign s      = sync2_q;
    assign c      = c_q;
    assign a      = a_q;
    assign reject = reject_q;

    // Two-flop synchronizer, bit order {quarter, dime, nickel}.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {btn_quarter, btn_dime, btn_nickel};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        patValue  = '0;
        patOneHot = 1'b1;
        case (pat_q)
            3'b001:  patValue = VAL_W'(NICKEL_VAL);
            3'b010:  patValue = VAL_W'(DIME_VAL);
            3'b100:  patValue = VAL_W'(QUARTER_VAL);
            default: patOneHot = 1'b0;
        endcase
    end

    // Reset lands in RELEASE so a button held through reset must be let go before it counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RELEASE;
            cnt_q    <= '0;
            pat_q    <= 3'b000;
            c_q      <= 1'b0;
            a_q      <= '0;
            reject_q <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s != 3'b000) begin
                        pat_q   <= s;
                        cnt_q   <= '0;
                        state_q <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (s != pat_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (patOneHot) begin
                            c_q     <= 1'b1;
                            a_q     <= patValue;
                            state_q <= PENDING;
                        end else begin
                            reject_q <= 1'b1;
                            state_q  <= RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PENDING: begin
                    if (tot_ld) begin
                        c_q     <= 1'b0;
                        a_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (s != 3'b000) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RELEASE;
                    cnt_q   <= '0;
                    c_q     <= 1'b0;
                    a_q     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed scenarios plus random button/ack traffic, checked every cycle
// against a run-length model of press acceptance, coin hold and release re-arming.
module tb_coin_acceptor;

    localparam int DEB = 4;

    logic       clk;
    logic       rst;
    logic       btn_nickel;
    logic       btn_dime;
    logic       btn_quarter;
    logic       tot_ld;
    logic       c;
    logic [7:0] a;
    logic       reject;

    int checks   = 0;
    int failures = 0;
    int rejSeen  = 0;

    logic [2:0] mSync1;
    logic [2:0] mSync2;
    logic [2:0] candPat;
    int         candRun;
    int         quietRun;
    int         pendVal;
    logic       disarmed;
    logic       mRej;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3),
        .VAL_W          (8),
        .NICKEL_VAL     (5),
        .DIME_VAL       (10),
        .QUARTER_VAL    (25)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_nickel (btn_nickel),
        .btn_dime   (btn_dime),
        .btn_quarter(btn_quarter),
        .tot_ld     (tot_ld),
        .c          (c),
        .a          (a),
        .reject     (reject)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int coinValue(input logic [2:0] p);
        case (p)
            3'b001:  return 5;
            3'b010:  return 10;
            3'b100:  return 25;
            default: return 0;
        endcase
    endfunction

    task automatic modelReset();
        mSync1   = 3'b000;
        mSync2   = 3'b000;
        candPat  = 3'b000;
        candRun  = 0;
        quietRun = 0;
        pendVal  = 0;
        disarmed = 1'b1;
        mRej     = 1'b0;
    endtask

    // A press counts once the same nonzero synchronized pattern has been seen on DEB edges
    // after the edge that captured it; afterwards DEB consecutive all-low edges re-arm.
    task automatic modelEdge();
        logic [2:0] s;
        s    = mSync2;
        mRej = 1'b0;
        if (pendVal != 0) begin
            if (tot_ld) begin
                pendVal  = 0;
                disarmed = 1'b1;
                quietRun = 0;
            end
        end else if (disarmed) begin
            if (s != 3'b000) begin
                quietRun = 0;
            end else begin
                quietRun++;
                if (quietRun == DEB) disarmed = 1'b0;
            end
        end else if (candPat == 3'b000) begin
            if (s != 3'b000) begin
                candPat = s;
                candRun = 0;
            end
        end else if (s != candPat) begin
            candPat = 3'b000;
        end else begin
            candRun++;
            if (candRun == DEB) begin
                if ($countones(candPat) == 1) pendVal = coinValue(candPat);
                else mRej = 1'b1;
                candPat  = 3'b000;
                disarmed = 1'b1;
                quietRun = 0;
            end
        end
        mSync2 = mSync1;
        mSync1 = {btn_quarter, btn_dime, btn_nickel};
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) modelReset();
        else modelEdge();
    end

    task automatic checkOutput(input string name, input logic expC, input logic [7:0] expA,
                               input logic expRej);
        checks++;
        if (c !== expC || a !== expA || reject !== expRej) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got c=%0b a=%0d reject=%0b, expected c=%0b a=%0d reject=%0b",
                     name, $time, c, a, reject, expC, expA, expRej);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int expected);
        checks++;
        if (got != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expected);
        end
    endtask

    // Inputs change on the falling edge and stay for the given number of rising edges.
    task automatic applyStimulus(input logic [2:0] btn, input logic ld, input int cycles);
        @(negedge clk);
        {btn_quarter, btn_dime, btn_nickel} = btn;
        tot_ld = ld;
        repeat (cycles - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        checkOutput("model", pendVal != 0, 8'(pendVal), mRej);
    end

    always @(negedge clk) begin
        if (reject === 1'b1) rejSeen++;
    end

    initial begin
        int rej0;
        logic [2:0] pat;
        int pick;
        int hold;

        rst         = 1'b0;
        btn_nickel  = 1'b0;
        btn_dime    = 1'b0;
        btn_quarter = 1'b0;
        tot_ld      = 1'b0;
        #22;
        rst = 1'b1;
        applyStimulus(3'b000, 1'b0, 8);

        $display("[TB] scenario 1: clean dime, hold, acknowledge");
        applyStimulus(3'b010, 1'b0, 1);
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            if (e == 6) checkOutput("t1_not_yet", 1'b0, 8'd0, 1'b0);
            if (e == 7) checkOutput("t1_accept", 1'b1, 8'd10, 1'b0);
        end
        applyStimulus(3'b010, 1'b0, 10);
        checkOutput("t1_held", 1'b1, 8'd10, 1'b0);
        applyStimulus(3'b010, 1'b1, 1);
        applyStimulus(3'b010, 1'b0, 1);
        checkOutput("t1_ack", 1'b0, 8'd0, 1'b0);
        applyStimulus(3'b010, 1'b0, 20);
        checkOutput("t1_no_repeat", 1'b0, 8'd0, 1'b0);
        applyStimulus(3'b000, 1'b0, 8);

        $display("[TB] scenario 2: bouncing quarter then nickel");
        applyStimulus(3'b100, 1'b0, 1);
        applyStimulus(3'b100, 1'b0, 1);
        applyStimulus(3'b000, 1'b0, 1);
        applyStimulus(3'b100, 1'b0, 1);
        applyStimulus(3'b100, 1'b0, 20);
        checkOutput("t2_quarter", 1'b1, 8'd25, 1'b0);
        applyStimulus(3'b100, 1'b1, 1);
        applyStimulus(3'b000, 1'b0, 6);
        applyStimulus(3'b001, 1'b0, 10);
        checkOutput("t2_nickel", 1'b1, 8'd5, 1'b0);
        applyStimulus(3'b001, 1'b1, 1);
        applyStimulus(3'b000, 1'b0, 8);

        $display("[TB] scenario 3: two buttons together");
        rej0 = rejSeen;
        applyStimulus(3'b011, 1'b0, 20);
        applyStimulus(3'b000, 1'b0, 6);
        checkCount("t3_reject_pulses", rejSeen - rej0, 1);
        applyStimulus(3'b010, 1'b0, 10);
        checkOutput("t3_dime", 1'b1, 8'd10, 1'b0);
        applyStimulus(3'b010, 1'b1, 1);
        applyStimulus(3'b000, 1'b0, 8);

        $display("[TB] scenario 4: reset with coin pending");
        applyStimulus(3'b010, 1'b0, 10);
        checkOutput("t4_pending", 1'b1, 8'd10, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 checkOutput("t4_reset_now", 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        applyStimulus(3'b010, 1'b0, 50);
        checkOutput("t4_held_through", 1'b0, 8'd0, 1'b0);
        applyStimulus(3'b000, 1'b0, 4);
        applyStimulus(3'b010, 1'b0, 10);
        checkOutput("t4_rearm", 1'b1, 8'd10, 1'b0);
        applyStimulus(3'b010, 1'b1, 1);
        applyStimulus(3'b000, 1'b0, 8);

        $display("[TB] scenario 5: stray acknowledges");
        applyStimulus(3'b000, 1'b1, 1);
        applyStimulus(3'b000, 1'b0, 2);
        checkOutput("t5_idle_ack", 1'b0, 8'd0, 1'b0);
        applyStimulus(3'b010, 1'b0, 3);
        applyStimulus(3'b010, 1'b1, 1);
        applyStimulus(3'b010, 1'b0, 8);
        checkOutput("t5_press", 1'b1, 8'd10, 1'b0);
        applyStimulus(3'b010, 1'b1, 1);
        applyStimulus(3'b000, 1'b0, 8);

        $display("[TB] scenario 6: short pulse");
        rej0 = rejSeen;
        applyStimulus(3'b001, 1'b0, 3);
        applyStimulus(3'b000, 1'b0, 10);
        checkOutput("t6_short", 1'b0, 8'd0, 1'b0);
        checkCount("t6_no_reject", rejSeen - rej0, 0);

        $display("[TB] random traffic");
        for (int seg = 0; seg < 300; seg++) begin
            pick = $urandom_range(0, 9);
            if (pick < 2) pat = 3'b000;
            else if (pick < 8) pat = 3'b001 << $urandom_range(0, 2);
            else begin
                pat = 3'($urandom_range(3, 7));
                if ($countones(pat) < 2) pat = 3'b110;
            end
            hold = $urandom_range(1, 12);
            for (int k = 0; k < hold; k++) begin
                applyStimulus(pat, $urandom_range(0, 3) == 0, 1);
            end
        end
        applyStimulus(3'b000, 1'b0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
